// File: rtl/dcache_loadpipe_l2.sv
// D-cache load pipeline stage 1: registers the accepted load, compares its tag
// against the per-way tag-array read data, issues the data-array read on a hit
// and forwards misses to the MSHR before sending a replay response.
module dcache_loadpipe_l2 #(
  parameter int TAG_ARRAY_IDX_HIGH = 11,
  parameter int TAG_ARRAY_IDX_LOW  = 6,
  parameter int TAG_WIDTH          = 52,
  parameter int WAYS               = 2,
  parameter int DATA_WIDTH         = 64
) (
  input  logic                                          clock,
  input  logic                                          reset,
  input  logic                                          flush,
  input  logic                                          fromldu_req_valid,
  output logic                                          fromldu_req_ready,
  input  logic [63:0]                                   fromldu_req_vaddr,
  input  logic [WAYS-1:0]                               tagarray_rd_valid,
  input  logic [WAYS*TAG_WIDTH-1:0]                     tagarray_rd_tag,
  output logic                                          dataarray_rd_en,
  output logic [TAG_ARRAY_IDX_HIGH-TAG_ARRAY_IDX_LOW:0] dataarray_rd_set,
  output logic [$clog2(WAYS)-1:0]                       dataarray_rd_way,
  output logic [TAG_ARRAY_IDX_LOW-4:0]                  dataarray_rd_bank,
  input  logic [DATA_WIDTH-1:0]                         dataarray_rd_data,
  output logic                                          miss_req_valid,
  input  logic                                          miss_req_ready,
  output logic [63:0]                                   miss_req_paddr,
  output logic                                          toldu_resp_valid,
  output logic                                          toldu_resp_miss,
  output logic [DATA_WIDTH-1:0]                         toldu_resp_data
);

  localparam int WAY_W = $clog2(WAYS);

  typedef enum logic [1:0] {IDLE, MISS_REQ, MISS_RESP} state_t;

  state_t                        state;
  logic                          s1_valid;
  logic [63:3]                   s1_vaddr;
  logic                          s2_valid;
  logic [63:TAG_ARRAY_IDX_LOW]   miss_addr;
  logic [WAYS-1:0]               hit_vec;
  logic [WAY_W-1:0]              hit_way;
  logic                          s1_hit;
  logic                          s1_miss;
  logic                          fire;
  logic                          resp_ok;
  logic                          unused_vaddr_lsb;

  // Byte offset within the 8-byte bank never affects the lookup.
  assign unused_vaddr_lsb = ^fromldu_req_vaddr[2:0];

  // Per-way tag match against the tag-array data returned this cycle.
  for (genvar gi = 0; gi < WAYS; gi++) begin : g_cmp
    assign hit_vec[gi] = tagarray_rd_valid[gi] &
      (tagarray_rd_tag[gi*TAG_WIDTH +: TAG_WIDTH] == s1_vaddr[63:TAG_ARRAY_IDX_HIGH+1]);
  end

  // Encode the hit way; scanning downward lets the lowest matching way win.
  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
    end
  end

  assign s1_hit  = s1_valid & (|hit_vec);
  assign s1_miss = s1_valid & ~(|hit_vec);

  // A miss sitting in s1 blocks the accept so the s0 tag read is not wasted.
  assign fromldu_req_ready = ~reset & (state == IDLE) & ~flush & ~s1_miss;
  assign fire              = fromldu_req_valid & fromldu_req_ready;

  assign dataarray_rd_en   = ~reset & s1_hit;
  assign dataarray_rd_set  = s1_vaddr[TAG_ARRAY_IDX_HIGH:TAG_ARRAY_IDX_LOW];
  assign dataarray_rd_bank = s1_vaddr[TAG_ARRAY_IDX_LOW-1:3];
  assign dataarray_rd_way  = hit_way;

  assign miss_req_valid = ~reset & (state == MISS_REQ);
  assign miss_req_paddr = reset ? 64'd0 : {miss_addr, {TAG_ARRAY_IDX_LOW{1'b0}}};

  // A flush kills any response that would leave in the same cycle.
  assign resp_ok          = ~reset & ~flush;
  assign toldu_resp_valid = resp_ok & (s2_valid | (state == MISS_RESP));
  assign toldu_resp_miss  = resp_ok & (state == MISS_RESP);
  assign toldu_resp_data  = (resp_ok & s2_valid) ? dataarray_rd_data : '0;

  // s1/s2 pipeline registers; flush empties both stages.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_vaddr <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= fire & ~flush;
      if (fire) s1_vaddr <= fromldu_req_vaddr[63:3];
      s2_valid <= s1_hit & ~flush;
    end
  end

  // Miss FSM: capture the line address, hold the MSHR request, then replay.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      miss_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (s1_miss & ~flush) begin
            state     <= MISS_REQ;
            miss_addr <= s1_vaddr[63:TAG_ARRAY_IDX_LOW];
          end
        end
        MISS_REQ: begin
          if (flush)               state <= IDLE;
          else if (miss_req_ready) state <= MISS_RESP;
        end
        MISS_RESP: state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_loadpipe_l2.sv
// Self-checking bench for dcache_loadpipe_l2: a tag/data array model, a
// scoreboard fed at s0 fire and drained at the DUT outputs, a vector table and
// hand-timed sequences for misses, flush and reset.
module tb_dcache_loadpipe_l2;

  logic         clock = 1'b0;
  logic         reset;
  logic         flush;
  logic         fromldu_req_valid;
  logic         fromldu_req_ready;
  logic [63:0]  fromldu_req_vaddr;
  logic [1:0]   tagarray_rd_valid;
  logic [103:0] tagarray_rd_tag;
  logic         dataarray_rd_en;
  logic [5:0]   dataarray_rd_set;
  logic [0:0]   dataarray_rd_way;
  logic [2:0]   dataarray_rd_bank;
  logic [63:0]  dataarray_rd_data;
  logic         miss_req_valid;
  logic         miss_req_ready;
  logic [63:0]  miss_req_paddr;
  logic         toldu_resp_valid;
  logic         toldu_resp_miss;
  logic [63:0]  toldu_resp_data;

  dcache_loadpipe_l2 dut (
    .clock             (clock),
    .reset             (reset),
    .flush             (flush),
    .fromldu_req_valid (fromldu_req_valid),
    .fromldu_req_ready (fromldu_req_ready),
    .fromldu_req_vaddr (fromldu_req_vaddr),
    .tagarray_rd_valid (tagarray_rd_valid),
    .tagarray_rd_tag   (tagarray_rd_tag),
    .dataarray_rd_en   (dataarray_rd_en),
    .dataarray_rd_set  (dataarray_rd_set),
    .dataarray_rd_way  (dataarray_rd_way),
    .dataarray_rd_bank (dataarray_rd_bank),
    .dataarray_rd_data (dataarray_rd_data),
    .miss_req_valid    (miss_req_valid),
    .miss_req_ready    (miss_req_ready),
    .miss_req_paddr    (miss_req_paddr),
    .toldu_resp_valid  (toldu_resp_valid),
    .toldu_resp_miss   (toldu_resp_miss),
    .toldu_resp_data   (toldu_resp_data)
  );

  always #5 clock = ~clock;

  typedef struct { logic [63:0] vaddr; logic hit; logic way; } vec_t;
  typedef struct { logic miss; logic [63:0] data; } resp_t;
  typedef struct { logic [5:0] set; logic way; logic [2:0] bank; } rd_t;

  resp_t       resp_q[$];
  rd_t         rd_q[$];
  logic [63:0] miss_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        cur_hit = 1'b0;
  logic        cur_way = 1'b0;

  // Tag array model: way1 in the upper half of each entry.
  logic [103:0] ttag[64];
  logic [1:0]   tval[64];
  logic [5:0]   s1_set_tb = 6'd0;

  assign tagarray_rd_tag   = ttag[s1_set_tb];
  assign tagarray_rd_valid = tval[s1_set_tb];

  always @(posedge clock)
    if (fromldu_req_valid && fromldu_req_ready) s1_set_tb <= fromldu_req_vaddr[11:6];

  function automatic logic [63:0] dhash(input logic [5:0] s, input logic w, input logic [2:0] b);
    if (s == 6'd2 && w == 1'b1 && b == 3'd5) return 64'hDEADBEEF_CAFEF00D;
    return 64'h0123_4567_0000_0000 | {54'd0, s, w, b} | ({54'd0, s, w, b} << 40);
  endfunction

  // Data array model: one-cycle registered read, garbage when not enabled.
  always @(posedge clock)
    dataarray_rd_data <= dataarray_rd_en ?
      dhash(dataarray_rd_set, dataarray_rd_way[0], dataarray_rd_bank) : 64'hBAD0_BAD0_BAD0_BAD0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: drain at the outputs first, then record any new s0 fire.
  always @(negedge clock) begin
    if (!reset) begin
      if (dataarray_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", dataarray_rd_en, 1'b0);
        else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_set", dataarray_rd_set, r.set);
          check("rd_way", dataarray_rd_way, r.way);
          check("rd_bank", dataarray_rd_bank, r.bank);
        end
      end
      if (miss_req_valid && miss_req_ready) begin
        if (miss_q.size() == 0) check("miss_unexpected", miss_req_valid, 1'b0);
        else check("miss_paddr", miss_req_paddr, miss_q.pop_front());
      end
      if (toldu_resp_valid) begin
        if (resp_q.size() == 0) check("resp_unexpected", toldu_resp_valid, 1'b0);
        else begin
          resp_t e;
          e = resp_q.pop_front();
          check("resp_miss", toldu_resp_miss, e.miss);
          check("resp_data", toldu_resp_data, e.data);
          $display("[TB] resp miss=%0d data=%h", toldu_resp_miss, toldu_resp_data);
        end
      end
      if (fromldu_req_valid && fromldu_req_ready) begin
        resp_t e;
        logic [5:0] s;
        logic [2:0] b;
        s = fromldu_req_vaddr[11:6];
        b = fromldu_req_vaddr[5:3];
        e.miss = ~cur_hit;
        e.data = cur_hit ? dhash(s, cur_way, b) : 64'd0;
        resp_q.push_back(e);
        if (cur_hit) rd_q.push_back('{set: s, way: cur_way, bank: b});
        else miss_q.push_back(fromldu_req_vaddr & ~64'h3F);
        $display("[TB] fire vaddr=%h hit=%0d way=%0d", fromldu_req_vaddr, cur_hit, cur_way);
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic drive_req(input logic [63:0] a, input logic h, input logic w);
    fromldu_req_vaddr = a;
    cur_hit           = h;
    cur_way           = w;
    fromldu_req_valid = 1'b1;
  endtask

  task automatic idle_req;
    fromldu_req_valid = 1'b0;
  endtask

  task automatic clear_sb;
    resp_q.delete();
    rd_q.delete();
    miss_q.delete();
  endtask

  vec_t tv[7];

  initial begin
    for (int i = 0; i < 64; i++) begin
      ttag[i] = '0;
      tval[i] = 2'b00;
    end
    ttag[2] = {52'h12345, 52'hABC}; tval[2] = 2'b11;
    ttag[5] = {52'h777,   52'h777}; tval[5] = 2'b11;
    ttag[9] = {52'h66,    52'h55};  tval[9] = 2'b10;

    tv[0] = '{vaddr: 64'h1234_50A8, hit: 1'b1, way: 1'b1};
    tv[1] = '{vaddr: 64'h00AB_C080, hit: 1'b1, way: 1'b0};
    tv[2] = '{vaddr: 64'h0077_7158, hit: 1'b1, way: 1'b0};
    tv[3] = '{vaddr: 64'h0005_5240, hit: 1'b0, way: 1'b0};
    tv[4] = '{vaddr: 64'h0006_6278, hit: 1'b1, way: 1'b1};
    tv[5] = '{vaddr: 64'h8000_0044, hit: 1'b0, way: 1'b0};
    tv[6] = '{vaddr: 64'h1234_6080, hit: 1'b0, way: 1'b0};

    // Reset: outputs quiet and ready low even with a pending request.
    reset = 1'b1; flush = 1'b0; miss_req_ready = 1'b1;
    drive_req(64'h1234_50A8, 1'b1, 1'b1);
    repeat (3) step;
    @(negedge clock);
    check("rst_ready", fromldu_req_ready, 1'b0);
    check("rst_rd_en", dataarray_rd_en, 1'b0);
    check("rst_mreq_valid", miss_req_valid, 1'b0);
    check("rst_resp_valid", toldu_resp_valid, 1'b0);
    check("rst_resp_miss", toldu_resp_miss, 1'b0);
    check("rst_resp_data", toldu_resp_data, 64'd0);
    check("rst_paddr", miss_req_paddr, 64'd0);
    step; reset = 1'b0; idle_req;

    // Single hit with exact latency.
    step; drive_req(64'h1234_50A8, 1'b1, 1'b1);
    @(negedge clock); check("hit_ready", fromldu_req_ready, 1'b1);
    step; idle_req;
    @(negedge clock);
    check("hit_rd_en", dataarray_rd_en, 1'b1);
    check("hit_set", dataarray_rd_set, 6'h2);
    check("hit_bank", dataarray_rd_bank, 3'd5);
    check("hit_way", dataarray_rd_way, 1'b1);
    check("hit_no_early_resp", toldu_resp_valid, 1'b0);
    step; @(negedge clock);
    check("hit_resp_valid", toldu_resp_valid, 1'b1);
    check("hit_resp_miss", toldu_resp_miss, 1'b0);
    check("hit_resp_data", toldu_resp_data, 64'hDEADBEEF_CAFEF00D);
    step; @(negedge clock);
    check("hit_resp_pulse", toldu_resp_valid, 1'b0);

    // Back-to-back hits: one accept per cycle, four consecutive responses.
    for (int c = 0; c < 8; c++) begin
      step;
      if (c < 4) drive_req(tv[(c == 3) ? 4 : c].vaddr, 1'b1, tv[(c == 3) ? 4 : c].way);
      else idle_req;
      @(negedge clock);
      if (c < 4) check("b2b_ready", fromldu_req_ready, 1'b1);
      if (c >= 2 && c < 6) check("b2b_resp_valid", toldu_resp_valid, 1'b1);
      if (c == 6) check("b2b_resp_end", toldu_resp_valid, 1'b0);
    end

    // Miss with MSHR accept delayed by three cycles.
    miss_req_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step;
      if (c == 0) drive_req(64'h8000_0044, 1'b0, 1'b0); else idle_req;
      miss_req_ready = (c == 5);
      @(negedge clock);
      if (c == 0) check("miss_ready0", fromldu_req_ready, 1'b1);
      if (c == 1) begin
        check("miss_ready1", fromldu_req_ready, 1'b0);
        check("miss_no_req_yet", miss_req_valid, 1'b0);
      end
      if (c >= 2 && c <= 5) begin
        check("miss_req_held", miss_req_valid, 1'b1);
        check("miss_paddr_held", miss_req_paddr, 64'h8000_0040);
        check("miss_ready_blocked", fromldu_req_ready, 1'b0);
        check("miss_no_resp", toldu_resp_valid, 1'b0);
      end
      if (c == 6) begin
        check("miss_resp_valid", toldu_resp_valid, 1'b1);
        check("miss_resp_miss", toldu_resp_miss, 1'b1);
        check("miss_resp_data", toldu_resp_data, 64'd0);
        check("miss_req_dropped", miss_req_valid, 1'b0);
        check("miss_ready_resp", fromldu_req_ready, 1'b0);
      end
      if (c == 7) begin
        check("miss_ready_back", fromldu_req_ready, 1'b1);
        check("miss_resp_single", toldu_resp_valid, 1'b0);
      end
    end

    // Miss following a hit: the miss in s1 blocks the next accept.
    miss_req_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      step;
      if (c == 0) drive_req(64'h00AB_C080, 1'b1, 1'b0);
      else if (c == 1) drive_req(64'h1234_6080, 1'b0, 1'b0);
      else if (c == 2) drive_req(64'h0077_7158, 1'b1, 1'b0);
      else if (c == 6) idle_req;
      @(negedge clock);
      if (c <= 1) check("mah_ready_early", fromldu_req_ready, 1'b1);
      if (c == 2) begin
        check("mah_ready_blocked", fromldu_req_ready, 1'b0);
        check("mah_hit_resp", toldu_resp_valid, 1'b1);
        check("mah_hit_resp_miss", toldu_resp_miss, 1'b0);
      end
      if (c == 3) check("mah_miss_req", miss_req_valid, 1'b1);
      if (c >= 3 && c <= 4) check("mah_ready_fsm", fromldu_req_ready, 1'b0);
      if (c == 4) check("mah_replay", toldu_resp_miss, 1'b1);
      if (c == 5) check("mah_ready_back", fromldu_req_ready, 1'b1);
      if (c == 7) check("mah_late_hit_resp", toldu_resp_valid, 1'b1);
    end

    // Flush with hits in s1 and s2.
    for (int c = 0; c < 5; c++) begin
      step;
      if (c == 0) drive_req(64'h0006_6278, 1'b1, 1'b1);
      else if (c == 1) drive_req(64'h1234_50A8, 1'b1, 1'b1);
      else idle_req;
      flush = (c == 2);
      if (c == 3) clear_sb;
      @(negedge clock);
      if (c == 2) check("fl_ready_low", fromldu_req_ready, 1'b0);
      if (c >= 3) check("fl_no_resp", toldu_resp_valid, 1'b0);
      if (c == 4) check("fl_ready_back", fromldu_req_ready, 1'b1);
    end

    // Flush during MISS_REQ with the MSHR not ready: request withdrawn.
    miss_req_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step;
      if (c == 0) drive_req(64'h0005_5240, 1'b0, 1'b0); else idle_req;
      flush = (c == 3);
      if (c == 4) clear_sb;
      @(negedge clock);
      if (c == 2 || c == 3) check("flr0_req_valid", miss_req_valid, 1'b1);
      if (c == 4) check("flr0_req_dropped", miss_req_valid, 1'b0);
      if (c >= 4) check("flr0_no_resp", toldu_resp_valid, 1'b0);
      if (c == 5) check("flr0_ready", fromldu_req_ready, 1'b1);
    end

    // Flush during MISS_REQ with the MSHR ready: handshake counts, no replay.
    for (int c = 0; c < 5; c++) begin
      step;
      if (c == 0) drive_req(64'h1234_6080, 1'b0, 1'b0); else idle_req;
      flush          = (c == 2);
      miss_req_ready = (c == 2);
      if (c == 3) begin
        check("flr1_handshake", miss_q.size(), 0);
        clear_sb;
      end
      @(negedge clock);
      if (c == 2) check("flr1_req_valid", miss_req_valid, 1'b1);
      if (c >= 3) begin
        check("flr1_no_resp", toldu_resp_valid, 1'b0);
        check("flr1_req_gone", miss_req_valid, 1'b0);
      end
      if (c == 4) check("flr1_ready", fromldu_req_ready, 1'b1);
    end

    // Reset in the middle of MISS_REQ.
    miss_req_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step;
      if (c == 0) drive_req(64'h8000_0044, 1'b0, 1'b0); else idle_req;
      reset = (c == 3 || c == 4);
      if (c == 4) clear_sb;
      @(negedge clock);
      if (c == 2) check("rmid_req_valid", miss_req_valid, 1'b1);
      if (c == 4) begin
        check("rmid_ready", fromldu_req_ready, 1'b0);
        check("rmid_req_valid0", miss_req_valid, 1'b0);
        check("rmid_paddr0", miss_req_paddr, 64'd0);
        check("rmid_rd_en0", dataarray_rd_en, 1'b0);
        check("rmid_resp0", toldu_resp_valid, 1'b0);
        check("rmid_resp_miss0", toldu_resp_miss, 1'b0);
        check("rmid_resp_data0", toldu_resp_data, 64'd0);
      end
      if (c == 5) begin
        check("rmid_ready_back", fromldu_req_ready, 1'b1);
        check("rmid_no_req", miss_req_valid, 1'b0);
      end
    end

    // Vector table: each entry issued as soon as the pipe accepts it.
    miss_req_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      int k;
      step;
      drive_req(tv[i].vaddr, tv[i].hit, tv[i].way);
      k = 0;
      @(negedge clock);
      while (!fromldu_req_ready && k < 50) begin
        step;
        @(negedge clock);
        k++;
      end
      check("tv_accept", fromldu_req_ready, 1'b1);
    end
    step; idle_req;

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 100 && (resp_q.size() != 0 || rd_q.size() != 0 || miss_q.size() != 0); k++)
      step;
    step;
    check("drain_resp_q", resp_q.size(), 0);
    check("drain_rd_q", rd_q.size(), 0);
    check("drain_miss_q", miss_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
